fsm_bram_write_row: RTL and testbench

- Write-back counterpart of the softmax row reader.
- Accepts one N-element vector from the softmax datapath in a single cycle and stores it in a local buffer.
- Writes the vector to a BRAM write port one word per cycle, at consecutive addresses starting at a caller-supplied base.
- Stalls cleanly whenever the BRAM port is not granted, then pulses done once the whole row is committed.

---
 rtl/fsm_bram_write_row.sv | 107 ++++++++++
 tb/tb_fsm_bram_write_row.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_bram_write_row.sv
// Write-back stage for one softmax row.
// Captures an N-element vector in a single cycle, then streams it to a BRAM
// write port one word per granted cycle, starting at a caller-supplied base.
// Pulses done for one cycle once the whole row has been committed.
module fsm_bram_write_row #(
  parameter int BIT_WIDTH  = 16,
  parameter int N          = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic [N*BIT_WIDTH-1:0]    i_data,
  input  logic [ADDR_WIDTH-1:0]     i_base_addr,
  input  logic                      bram_grant,
  output logic                      bram_we,
  output logic [ADDR_WIDTH-1:0]     bram_addr,
  output logic [BIT_WIDTH-1:0]      bram_dataB,
  output logic                      busy,
  output logic                      done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_COL = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [CW-1:0]         col_cnt;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [BIT_WIDTH-1:0]  row_buf [N];
  logic                  accept;

  // A row is taken only while idle; i_valid in any other state is ignored.
  assign accept = i_valid && (state == IDLE);

  // State register; reset returns to IDLE at once so bram_we drops without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Row buffer, base address and column counter: loaded on accept, counter advances on each granted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt  <= '0;
      base_reg <= '0;
      for (int j = 0; j < N; j++) begin
        row_buf[j] <= '0;
      end
    end else if (accept) begin
      col_cnt  <= '0;
      base_reg <= i_base_addr;
      for (int j = 0; j < N; j++) begin
        row_buf[j] <= i_data[j*BIT_WIDTH +: BIT_WIDTH];
      end
    end else if ((state == WRITE) && bram_grant) begin
      col_cnt <= col_cnt + CW'(1);
    end
  end

  // Next-state and output decode; address and data follow col_cnt, so they hold naturally while grant is low.
  always_comb begin
    next_state = state;
    i_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_dataB = '0;
    case (state)
      IDLE: begin
        i_ready = 1'b1;
        if (i_valid) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        busy       = 1'b1;
        bram_we    = bram_grant;
        bram_addr  = base_reg + ADDR_WIDTH'(col_cnt);
        bram_dataB = row_buf[col_cnt];
        if (bram_grant && (col_cnt == LAST_COL)) begin
          next_state = DONE_ST;
        end
      end
      DONE_ST: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_bram_write_row.sv
// Self-checking bench for fsm_bram_write_row.
// Expected BRAM writes are queued when a row is offered and popped by a
// monitor as writes appear; each scenario task checks protocol timing inline.
module tb_fsm_bram_write_row;

  localparam int N  = 32;
  localparam int BW = 16;
  localparam int AW = 10;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              i_valid;
  logic              i_ready;
  logic [N*BW-1:0]   i_data;
  logic [AW-1:0]     i_base_addr;
  logic              bram_grant;
  logic              bram_we;
  logic [AW-1:0]     bram_addr;
  logic [BW-1:0]     bram_dataB;
  logic              busy;
  logic              done;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  fsm_bram_write_row #(
    .BIT_WIDTH (BW),
    .N         (N),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_data     (i_data),
    .i_base_addr(i_base_addr),
    .bram_grant (bram_grant),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_dataB (bram_dataB),
    .busy       (busy),
    .done       (done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && (bram_we !== 1'b0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, expected no write", bram_addr, bram_dataB);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ((bram_addr !== e.addr) || (bram_dataB !== e.data)) begin
          failures++;
          $display("[TB] FAIL write_content: got addr=%0d data=%h, expected addr=%0d data=%h",
                   bram_addr, bram_dataB, e.addr, e.data);
        end
      end
    end
  end

  function automatic logic [N*BW-1:0] make_row(input int kind);
    logic [N*BW-1:0] r;
    int v;
    r = '0;
    for (int j = 0; j < N; j++) begin
      case (kind)
        0:       v = j + 1;
        1:       v = -(j + 1);
        2:       v = j * 7 + 3;
        3:       v = 32768 ^ (j * 11);
        4:       v = j * 5 - 40;
        default: v = 1000 - j * 13;
      endcase
      r[j*BW +: BW] = v[BW-1:0];
    end
    return r;
  endfunction

  task automatic push_row(input logic [N*BW-1:0] d, input logic [AW-1:0] b);
    exp_t e;
    for (int j = 0; j < N; j++) begin
      e.addr = AW'(int'(b) + j);
      e.data = d[j*BW +: BW];
      exp_q.push_back(e);
    end
  endtask

  task automatic accept_row(input logic [N*BW-1:0] d, input logic [AW-1:0] b);
    @(posedge clk);
    #1;
    i_valid     = 1'b1;
    i_data      = d;
    i_base_addr = b;
    push_row(d, b);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ((i_ready !== 1'b1) || (bram_we !== 1'b0) || (bram_addr !== '0) ||
        (bram_dataB !== '0) || (busy !== 1'b0) || (done !== 1'b0)) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got ready=%b we=%b addr=%0d data=%h busy=%b done=%b, expected 1 0 0 0 0 0",
               i_ready, bram_we, bram_addr, bram_dataB, busy, done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ((i_ready !== 1'b1) || (busy !== 1'b0) || (bram_we !== 1'b0)) begin
      failures++;
      $display("[TB] FAIL reset_release_idle: got ready=%b busy=%b we=%b, expected 1 0 0", i_ready, busy, bram_we);
    end
  endtask

  task automatic test_basic();
    bram_grant = 1'b1;
    accept_row(make_row(0), AW'(0));
    for (int cyc = 1; cyc <= N + 2; cyc++) begin
      @(negedge clk);
      checks++;
      if (cyc <= N) begin
        if ((bram_we !== 1'b1) || (busy !== 1'b1) || (done !== 1'b0) || (i_ready !== 1'b0)) begin
          failures++;
          $display("[TB] FAIL basic_write_cycle%0d: got we=%b busy=%b done=%b ready=%b, expected 1 1 0 0",
                   cyc, bram_we, busy, done, i_ready);
        end
      end else if (cyc == N + 1) begin
        if ((done !== 1'b1) || (bram_we !== 1'b0) || (busy !== 1'b1) || (i_ready !== 1'b0)) begin
          failures++;
          $display("[TB] FAIL basic_done: got done=%b we=%b busy=%b ready=%b, expected 1 0 1 0",
                   done, bram_we, busy, i_ready);
        end
      end else begin
        if ((done !== 1'b0) || (i_ready !== 1'b1) || (busy !== 1'b0)) begin
          failures++;
          $display("[TB] FAIL basic_ready_return: got done=%b ready=%b busy=%b, expected 0 1 0", done, i_ready, busy);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL basic_all_written: got %0d writes left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_stall();
    logic [N*BW-1:0] d;
    logic [BW-1:0]   exp_data;
    logic [AW-1:0]   exp_addr;
    logic            g;
    logic            stalled_last;
    int              col;
    int              cyc;
    d = make_row(0);
    bram_grant = 1'b1;
    accept_row(d, AW'(0));
    col = 0;
    cyc = 1;
    stalled_last = 1'b0;
    while ((col < N) && (cyc < 100)) begin
      g = !(((cyc >= 5) && (cyc <= 7)) || ((col == N - 1) && !stalled_last));
      if ((col == N - 1) && !g) stalled_last = 1'b1;
      bram_grant = g;
      exp_addr = AW'(col);
      exp_data = d[col*BW +: BW];
      @(negedge clk);
      checks++;
      if ((bram_we !== g) || (bram_addr !== exp_addr) || (bram_dataB !== exp_data) || (done !== 1'b0)) begin
        failures++;
        $display("[TB] FAIL stall_cycle%0d: got we=%b addr=%0d data=%h done=%b, expected we=%b addr=%0d data=%h done=0",
                 cyc, bram_we, bram_addr, bram_dataB, done, g, exp_addr, exp_data);
      end
      if (g) col++;
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc >= 100) begin
      failures++;
      $display("[TB] FAIL stall_timeout: got %0d columns, expected %0d", col, N);
    end
    bram_grant = 1'b1;
    @(negedge clk);
    checks++;
    if ((done !== 1'b1) || (bram_we !== 1'b0)) begin
      failures++;
      $display("[TB] FAIL stall_done: got done=%b we=%b, expected 1 0", done, bram_we);
    end
    @(negedge clk);
    checks++;
    if ((done !== 1'b0) || (i_ready !== 1'b1)) begin
      failures++;
      $display("[TB] FAIL stall_ready_return: got done=%b ready=%b, expected 0 1", done, i_ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL stall_all_written: got %0d writes left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] b;
    logic [AW-1:0] exp_addr;
    b = AW'(1020);
    bram_grant = 1'b1;
    accept_row(make_row(1), b);
    for (int cyc = 1; cyc <= N + 1; cyc++) begin
      @(negedge clk);
      checks++;
      if (cyc <= N) begin
        exp_addr = AW'(int'(b) + cyc - 1);
        if ((bram_we !== 1'b1) || (bram_addr !== exp_addr)) begin
          failures++;
          $display("[TB] FAIL wrap_addr_cycle%0d: got we=%b addr=%0d, expected we=1 addr=%0d",
                   cyc, bram_we, bram_addr, exp_addr);
        end
      end else if (done !== 1'b1) begin
        failures++;
        $display("[TB] FAIL wrap_done: got done=%b, expected 1", done);
      end
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL wrap_all_written: got %0d writes left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [N*BW-1:0] da;
    logic [N*BW-1:0] db;
    da = make_row(2);
    db = make_row(3);
    bram_grant = 1'b1;
    @(posedge clk);
    #1;
    i_valid     = 1'b1;
    i_data      = da;
    i_base_addr = AW'(100);
    push_row(da, AW'(100));
    @(posedge clk);
    #1;
    i_data      = db;
    i_base_addr = AW'(300);
    push_row(db, AW'(300));
    for (int cyc = 1; cyc <= N + 2; cyc++) begin
      @(negedge clk);
      checks++;
      if (cyc <= N) begin
        if ((bram_we !== 1'b1) || (i_ready !== 1'b0)) begin
          failures++;
          $display("[TB] FAIL b2b_first_row_cycle%0d: got we=%b ready=%b, expected 1 0", cyc, bram_we, i_ready);
        end
      end else if (cyc == N + 1) begin
        if ((done !== 1'b1) || (bram_we !== 1'b0) || (i_ready !== 1'b0)) begin
          failures++;
          $display("[TB] FAIL b2b_done_no_accept: got done=%b we=%b ready=%b, expected 1 0 0", done, bram_we, i_ready);
        end
      end else begin
        if ((i_ready !== 1'b1) || (done !== 1'b0) || (bram_we !== 1'b0)) begin
          failures++;
          $display("[TB] FAIL b2b_second_accept: got ready=%b done=%b we=%b, expected 1 0 0", i_ready, done, bram_we);
        end
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    for (int cyc = 1; cyc <= N + 2; cyc++) begin
      @(negedge clk);
      checks++;
      if (cyc <= N) begin
        if ((bram_we !== 1'b1) || (busy !== 1'b1)) begin
          failures++;
          $display("[TB] FAIL b2b_second_row_cycle%0d: got we=%b busy=%b, expected 1 1", cyc, bram_we, busy);
        end
      end else if (cyc == N + 1) begin
        if (done !== 1'b1) begin
          failures++;
          $display("[TB] FAIL b2b_second_done: got done=%b, expected 1", done);
        end
      end else if (i_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL b2b_idle: got ready=%b, expected 1", i_ready);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL b2b_all_written: got %0d writes left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    bram_grant = 1'b1;
    accept_row(make_row(4), AW'(500));
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if ((bram_we !== 1'b1) || (bram_addr !== AW'(510))) begin
      failures++;
      $display("[TB] FAIL rstmid_col10: got we=%b addr=%0d, expected we=1 addr=510", bram_we, bram_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ((bram_we !== 1'b0) || (i_ready !== 1'b1) || (busy !== 1'b0) || (bram_addr !== '0) || (bram_dataB !== '0)) begin
      failures++;
      $display("[TB] FAIL rstmid_async: got we=%b ready=%b busy=%b addr=%0d data=%h, expected 0 1 0 0 0",
               bram_we, i_ready, busy, bram_addr, bram_dataB);
    end
    checks++;
    if (exp_q.size() != N - 10) begin
      failures++;
      $display("[TB] FAIL rstmid_partial_count: got %0d writes left, expected %0d", exp_q.size(), N - 10);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ((done !== 1'b0) || (i_ready !== 1'b1) || (bram_we !== 1'b0)) begin
        failures++;
        $display("[TB] FAIL rstmid_no_done: got done=%b ready=%b we=%b, expected 0 1 0", done, i_ready, bram_we);
      end
    end
    accept_row(make_row(5), AW'(0));
    for (int cyc = 1; cyc <= N + 1; cyc++) begin
      @(negedge clk);
      checks++;
      if ((cyc <= N) && ((bram_we !== 1'b1) || (bram_addr !== AW'(cyc - 1)))) begin
        failures++;
        $display("[TB] FAIL rstmid_next_row_cycle%0d: got we=%b addr=%0d, expected we=1 addr=%0d",
                 cyc, bram_we, bram_addr, cyc - 1);
      end else if ((cyc == N + 1) && (done !== 1'b1)) begin
        failures++;
        $display("[TB] FAIL rstmid_next_done: got done=%b, expected 1", done);
      end
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL rstmid_all_written: got %0d writes left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scenario sequence, then the one summary line.
  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    i_valid     = 1'b0;
    i_data      = '0;
    i_base_addr = '0;
    bram_grant  = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
